// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one external adder among N_REQ requesters.
// Each operation runs IDLE -> ISSUE -> WAIT -> RESP; the adder result is captured in WAIT.
module add_arbiter #(
    parameter int N_REQ  = 4,
    parameter int IN_WL  = 15,
    parameter int OUT_WL = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*IN_WL-1:0]      req_a,
    input  logic [N_REQ*IN_WL-1:0]      req_b,
    output logic                        add_rstb,
    output logic signed [IN_WL-1:0]     add_a,
    output logic signed [IN_WL-1:0]     add_b,
    input  logic signed [OUT_WL-1:0]    add_r,
    output logic                        resp_valid,
    output logic [$clog2(N_REQ)-1:0]    resp_id,
    output logic signed [OUT_WL-1:0]    resp_r,
    input  logic                        resp_ready,
    output logic                        busy,
    output logic [15:0]                 op_cnt
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                   state_q;
    logic [ID_W-1:0]          ptr_q;
    logic [ID_W-1:0]          cap_id_q;
    logic signed [IN_WL-1:0]  cap_a_q;
    logic signed [IN_WL-1:0]  cap_b_q;
    logic [ID_W-1:0]          resp_id_q;
    logic signed [OUT_WL-1:0] resp_r_q;
    logic [15:0]              op_cnt_q;
    logic                     add_rstb_q;

    logic                     found_d;
    logic [ID_W-1:0]          win_d;
    logic [ID_W:0]            idx_d;
    logic [ID_W-1:0]          ptr_d;
    logic signed [IN_WL-1:0]  sel_a_d;
    logic signed [IN_WL-1:0]  sel_b_d;
    logic                     handshake;

    // Search starts at ptr_q and wraps; the extra index bit keeps the wrap exact for any N_REQ.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        idx_d   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_d = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx_d >= (ID_W+1)'(N_REQ)) begin
                idx_d = idx_d - (ID_W+1)'(N_REQ);
            end
            if (!found_d && req_valid[idx_d[ID_W-1:0]]) begin
                found_d = 1'b1;
                win_d   = idx_d[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !rst && found_d) begin
            req_ready[win_d] = 1'b1;
        end
    end

    always_comb begin
        sel_a_d = '0;
        sel_b_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_d == ID_W'(i)) begin
                sel_a_d = req_a[i*IN_WL +: IN_WL];
                sel_b_d = req_b[i*IN_WL +: IN_WL];
            end
        end
    end

    assign ptr_d     = (win_d == ID_W'(N_REQ-1)) ? '0 : win_d + ID_W'(1);
    assign handshake = |req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cap_id_q   <= '0;
            cap_a_q    <= '0;
            cap_b_q    <= '0;
            resp_id_q  <= '0;
            resp_r_q   <= '0;
            op_cnt_q   <= '0;
            add_rstb_q <= 1'b0;
        end else begin
            add_rstb_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        cap_a_q  <= sel_a_d;
                        cap_b_q  <= sel_b_d;
                        cap_id_q <= win_d;
                        ptr_q    <= ptr_d;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    resp_r_q  <= add_r;
                    resp_id_q <= cap_id_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        op_cnt_q <= op_cnt_q + 16'd1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operands reach the adder only during ISSUE so it sees a clean zero otherwise.
    assign add_a      = (state_q == ISSUE) ? cap_a_q : '0;
    assign add_b      = (state_q == ISSUE) ? cap_b_q : '0;
    assign add_rstb   = add_rstb_q;
    assign resp_valid = (state_q == RESP);
    assign resp_id    = resp_id_q;
    assign resp_r     = resp_r_q;
    assign busy       = (state_q != IDLE);
    assign op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: directed cases plus random traffic, checked by a
// round-robin reference model feeding a response scoreboard.
module tb_add_arbiter;

    localparam int N  = 4;
    localparam int IW = 15;
    localparam int OW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*IW-1:0]   req_a;
    logic [N*IW-1:0]   req_b;
    logic              add_rstb;
    logic [IW-1:0]     add_a;
    logic [IW-1:0]     add_b;
    logic [OW-1:0]     add_r = '0;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic [OW-1:0]     resp_r;
    logic              resp_ready;
    logic              busy;
    logic [15:0]       op_cnt;

    add_arbiter #(.N_REQ(N), .IN_WL(IW), .OUT_WL(OW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_rstb(add_rstb), .add_a(add_a), .add_b(add_b), .add_r(add_r),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_r(resp_r),
        .resp_ready(resp_ready), .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // External shared adder: one-cycle registered sign-extended sum.
    always @(posedge clk) begin
        add_r <= add_rstb ? ({add_a[IW-1], add_a} + {add_b[IW-1], add_b}) : '0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input logic [IW-1:0] v);
        return int'($signed(v));
    endfunction

    typedef struct {
        logic [OW-1:0] r;
        int            id;
    } exp_t;

    exp_t        exp_q[$];
    int          dut_grants[$];
    logic [15:0] exp_cnt = '0;
    bit          started = 1'b0;

    // Reference model: round-robin choice, fixed 3-edge latency, captured operands.
    int          m_phase = 0;
    int          m_ptr   = 0;
    logic [IW-1:0] m_a = '0;
    logic [IW-1:0] m_b = '0;
    bit          m_rstb = 1'b0;

    initial forever begin
        @(negedge clk);
        #1;
        if (started) begin
            int w;
            logic [N-1:0] er;
            exp_t e;
            w = -1;
            if (!rst && m_phase == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
            end
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("resp_valid", 32'(resp_valid), 32'(m_phase == 3));
            chk("add_a", 32'(add_a), (m_phase == 1) ? 32'(m_a) : 32'd0);
            chk("add_b", 32'(add_b), (m_phase == 1) ? 32'(m_b) : 32'd0);
            chk("add_rstb", 32'(add_rstb), 32'(m_rstb));
            for (int j = 0; j < N; j++) if (req_ready[j]) dut_grants.push_back(j);
            m_rstb = !rst;
            if (rst) begin
                m_phase = 0;
                m_ptr   = 0;
                exp_q.delete();
            end else begin
                case (m_phase)
                    0: if (w >= 0) begin
                        m_a  = req_a[w*IW +: IW];
                        m_b  = req_b[w*IW +: IW];
                        e.r  = OW'(sx(m_a) + sx(m_b));
                        e.id = w;
                        exp_q.push_back(e);
                        m_ptr   = (w + 1) % N;
                        m_phase = 1;
                    end
                    1: m_phase = 2;
                    2: m_phase = 3;
                    default: if (resp_ready) m_phase = 0;
                endcase
            end
        end
    end

    // Scoreboard monitor: compares every presented response and tracks completions.
    initial forever begin
        @(negedge clk);
        if (started) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got resp_r 0x%0h id %0d, want no response at %0t",
                             resp_r, resp_id, $time);
                end else begin
                    chk("resp_r", 32'(resp_r), 32'(exp_q[0].r));
                    chk("resp_id", 32'(resp_id), 32'(exp_q[0].id));
                    if (resp_ready && !rst) void'(exp_q.pop_front());
                end
            end
            chk("op_cnt", 32'(op_cnt), 32'(exp_cnt));
            if (rst) exp_cnt = '0;
            else if (resp_valid && resp_ready) exp_cnt = exp_cnt + 16'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic [IW-1:0] a, input logic [IW-1:0] b);
        req_a[i*IW +: IW] = a;
        req_b[i*IW +: IW] = b;
    endtask

    task automatic wait_grant(input int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 12 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got no req_ready for requester %0d, want a grant", i);
        end
    endtask

    task automatic run_one(input int i, input logic [IW-1:0] a, input logic [IW-1:0] b,
                           output logic [OW-1:0] r, output int id, output int lat);
        bit ok;
        r = '0; id = -1; lat = 0;
        req_valid = '0;
        req_valid[i] = 1'b1;
        set_req(i, a, b);
        resp_ready = 1'b1;
        wait_grant(i, ok);
        @(posedge clk); #1;
        req_valid = '0;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                ok = 1'b1;
                r  = resp_r;
                id = int'(resp_id);
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: got no resp_valid for requester %0d, want a response", i);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [OW-1:0] r;
        int id, lat;
        bit ok;
        int want_g[5];

        rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_r", 32'(resp_r), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_op_cnt", 32'(op_cnt), 32'd0);
        chk("rst_add_rstb", 32'(add_rstb), 32'd0);
        exp_cnt = '0;
        rst = 1'b0; req_valid = '0;
        started = 1'b1;

        // Single request and sign extension.
        run_one(0, 15'd5, 15'd7, r, id, lat);
        chk("single_r", 32'(r), 32'h000C);
        chk("single_id", 32'(id), 32'd0);
        chk("single_latency", 32'(lat), 32'd3);
        chk("single_op_cnt", 32'(op_cnt), 32'd1);
        chk("add_rstb_released", 32'(add_rstb), 32'd1);
        run_one(2, 15'h7FFF, 15'h7FFF, r, id, lat);
        chk("sext_neg_r", 32'(r), 32'hFFFE);
        chk("sext_neg_id", 32'(id), 32'd2);
        run_one(3, 15'h3FFF, 15'h3FFF, r, id, lat);
        chk("sext_pos_r", 32'(r), 32'h7FFE);

        // Fairness with every requester asking.
        for (int i = 0; i < N; i++) set_req(i, IW'(i*100 + 1), IW'(i*3 + 2));
        dut_grants.delete();
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int c = 0; c < 40 && dut_grants.size() < 5; c++) begin
            @(posedge clk); #1;
        end
        req_valid = '0;
        for (int c = 0; c < 10 && busy; c++) begin
            @(posedge clk); #1;
        end
        want_g = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            chk("fair_order", (k < dut_grants.size()) ? 32'(dut_grants[k]) : 32'hFFFF_FFFF, 32'(want_g[k]));
        end

        // Backpressure: response must hold while resp_ready is low.
        req_valid = '0;
        req_valid[1] = 1'b1;
        set_req(1, 15'h0064, 15'h7FFD);
        resp_ready = 1'b0;
        wait_grant(1, ok);
        @(posedge clk); #1;
        req_valid = '1;
        for (int c = 0; c < 10 && !resp_valid; c++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_r", 32'(resp_r), 32'h0061);
            chk("bp_resp_id", 32'(resp_id), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        chk("bp_done_busy", 32'(busy), 32'd0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            rst        = ($urandom_range(0, 39) == 0);
            req_valid  = N'($urandom());
            req_a      = (N*IW)'({$urandom(), $urandom()});
            req_b      = (N*IW)'({$urandom(), $urandom()});
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; resp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset while in WAIT.
        req_valid = '0;
        req_valid[2] = 1'b1;
        set_req(2, 15'd9, 15'd4);
        wait_grant(2, ok);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_op_cnt", 32'(op_cnt), 32'd0);
        chk("abort_add_rstb", 32'(add_rstb), 32'd0);
        req_valid = '1;
        @(negedge clk);
        chk("abort_next_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        for (int c = 0; c < 10 && busy; c++) begin
            @(posedge clk); #1;
        end

        // Counter wrap from a preloaded near-full count.
        dut.op_cnt_q <= 16'hFFFE;
        exp_cnt = 16'hFFFE;
        run_one(1, 15'd1, 15'd2, r, id, lat);
        chk("wrap_ffff", 32'(op_cnt), 32'hFFFF);
        run_one(2, 15'd3, 15'd4, r, id, lat);
        chk("wrap_zero", 32'(op_cnt), 32'h0000);
        chk("wrap_r", 32'(r), 32'h0007);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one adder; legal range 2..8.
REQ-002 Parameter IN_WL, default 15: operand word length, two's complement.
REQ-003 Parameter OUT_WL, default 16: result word length, IN_WL+1.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester operation request.
REQ-007 req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a, req_b  input  N_REQ*IN_WL each  packed operands; requester i occupies bits [i*IN_WL +: IN_WL].
REQ-009 add_rstb  output  1  active-low reset to the shared adder, equal to ~rst, registered.
REQ-010 add_a, add_b  output  IN_WL each  operands to the shared adder.
REQ-011 add_r  input  OUT_WL  adder result, valid one clock after operands are presented.
REQ-012 resp_valid  output  1  result available.
REQ-013 resp_id  output  $clog2(N_REQ)  index of the requester owning resp_r.
REQ-014 resp_r  output  OUT_WL  sign-extended sum.
REQ-015 resp_ready  input  1  consumer accepts the response.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 op_cnt  output  16  count of completed responses, wraps 0xFFFF->0x0000.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-019 In IDLE, req_ready SHALL be combinational: one-hot for the winning valid requester, zero if none valid; zero in all other states.
REQ-020 Arbitration SHALL be round-robin: search starts at pointer ptr and wraps modulo N_REQ; the first requester with req_valid high wins.
REQ-021 On handshake (req_valid[i] & req_ready[i]), the block SHALL capture req_a[i], req_b[i], and id i into internal registers, set ptr to (i+1) mod N_REQ, and move to ISSUE.
REQ-022 In ISSUE, add_a/add_b SHALL drive the captured operands; next state WAIT.
REQ-023 In WAIT, the block SHALL register add_r into resp_r and the captured id into resp_id; next state RESP.
REQ-024 In RESP, resp_valid SHALL be 1 and resp_r/resp_id SHALL hold stable until resp_ready is sampled high.
REQ-025 When resp_ready is sampled high in RESP, the block SHALL increment op_cnt and return to IDLE; the first resp_valid cycle may be accepted.
REQ-026 Latency from the handshake edge to the first resp_valid cycle SHALL be 3 clocks; the minimum issue interval SHALL be 4 clocks.
REQ-027 Outside ISSUE, add_a and add_b SHALL be 0.
REQ-028 resp_ready while not in RESP SHALL be ignored.
REQ-029 Changes to req_valid/req_a/req_b after the handshake SHALL NOT affect the in-flight result.
REQ-030 The arbiter SHALL apply no further width arithmetic: resp_r equals add_r, which is {a[MSB],a}+{b[MSB],b} mod 2^OUT_WL.

Reset
REQ-031 When rst is sampled high, the following SHALL take effect the next cycle: state IDLE, ptr 0, resp_valid 0, resp_id 0, resp_r 0, op_cnt 0, captured registers 0, add_rstb 0.
REQ-032 Reset SHALL abort any in-flight operation in any state; the aborted result SHALL NOT be reported and op_cnt SHALL NOT increment.
REQ-033 req_ready SHALL be 0 during any cycle with rst high.
REQ-034 add_rstb SHALL return to 1 one cycle after rst deasserts.

Verification
REQ-035 Single request: req0 a=5, b=7, resp_ready=1 -> resp_valid 3 cycles after the handshake, resp_r=16'd12, resp_id=0, op_cnt=1.
REQ-036 Sign extension: a=15'h7FFF, b=15'h7FFF -> resp_r=16'hFFFE. Separately, a=15'h3FFF, b=15'h3FFF -> resp_r=16'h7FFE.
REQ-037 Fairness: all 4 req_valid held high with distinct operands -> grant order 0,1,2,3,0, each result tagged with the correct resp_id.
REQ-038 Backpressure: resp_ready low for 5 cycles in RESP -> resp_valid/resp_r/resp_id stable and req_ready=0 throughout; completion on the first resp_ready high.
REQ-039 Reset mid-operation: rst pulsed in WAIT -> next cycle resp_valid=0, busy=0, op_cnt unchanged at 0, add_rstb=0; the next request is granted starting from requester 0.
REQ-040 Counter wrap: op_cnt preloaded by 65535 completions -> next completion gives op_cnt=0.
